// File: rtl/mode_switch_controller.sv
// Mode arbiter: debounces mode_select, mutes the speaker for a fixed gap on every
// mode change, pulses a restart into the newly entered engine and muxes its outputs.
module mode_switch_controller #(
  parameter int NUM_MODES       = 3,
  parameter int MODE_W          = 3,
  parameter int LED_W           = 7,
  parameter int DEFAULT_MODE    = 0,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MUTE_CYCLES     = 500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MODE_W-1:0]          mode_select,
  input  logic [NUM_MODES-1:0]       src_speaker,
  input  logic [NUM_MODES*LED_W-1:0] src_led,
  output logic [MODE_W-1:0]          current_mode,
  output logic [NUM_MODES-1:0]       mode_active,
  output logic [NUM_MODES-1:0]       mode_restart,
  output logic                       switching,
  output logic                       speaker,
  output logic                       loud,
  output logic [LED_W-1:0]           led
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [DW-1:0]     DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MW-1:0]     MUTE_MAX = MW'(MUTE_CYCLES - 1);
  localparam logic [MODE_W-1:0] DEF_MODE = MODE_W'(DEFAULT_MODE);

  typedef enum logic {ACTIVE, MUTE} state_t;

  state_t                          state;
  logic [DW-1:0]                   dcnt;
  logic [MW-1:0]                   mcnt;
  logic [MODE_W-1:0]               cand;
  logic [MODE_W-1:0]               sel_ok;
  logic [MODE_W-1:0]               nxt_mode;
  logic                            accept;
  logic                            nxt_mute;
  logic                            spk_cur;
  logic [LED_W-1:0]                led_nxt;
  logic [NUM_MODES-1:0][LED_W-1:0] led_arr;

  function automatic logic [NUM_MODES-1:0] onehot(input logic [MODE_W-1:0] m);
    onehot = '0;
    for (int i = 0; i < NUM_MODES; i++) onehot[i] = (m == MODE_W'(i));
  endfunction

  assign led_arr = src_led;

  // Extra MSB keeps the range compare correct when NUM_MODES == 2**MODE_W.
  assign sel_ok = ({1'b0, mode_select} < (MODE_W+1)'(NUM_MODES)) ? mode_select : DEF_MODE;

  assign accept   = (dcnt == DB_MAX) && (cand != current_mode);
  assign nxt_mode = accept ? cand : current_mode;
  assign nxt_mute = accept || ((state == MUTE) && (mcnt != '0));

  // Loop compare instead of a direct index keeps out-of-range modes at 0, never X.
  always_comb begin
    spk_cur = 1'b0;
    led_nxt = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (current_mode == MODE_W'(i)) spk_cur = src_speaker[i];
      if (nxt_mode == MODE_W'(i))     led_nxt = led_arr[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= MUTE;
      mcnt         <= MUTE_MAX;
      dcnt         <= '0;
      cand         <= DEF_MODE;
      current_mode <= DEF_MODE;
      mode_active  <= onehot(DEF_MODE);
      mode_restart <= '0;
      switching    <= 1'b0;
      speaker      <= 1'b0;
      loud         <= 1'b0;
      led          <= '0;
    end else begin
      if (sel_ok != cand) begin
        cand <= sel_ok;
        dcnt <= '0;
      end else if (dcnt != DB_MAX) begin
        dcnt <= dcnt + 1'b1;
      end

      // Acceptance beats mute expiry and reloads a full gap.
      if (accept) begin
        state <= MUTE;
        mcnt  <= MUTE_MAX;
      end else if (state == MUTE) begin
        if (mcnt == '0) state <= ACTIVE;
        else            mcnt  <= mcnt - 1'b1;
      end

      current_mode <= nxt_mode;
      mode_active  <= onehot(nxt_mode);
      mode_restart <= accept ? onehot(cand) : '0;
      switching    <= nxt_mute;
      loud         <= ~nxt_mute;
      speaker      <= nxt_mute ? 1'b0 : spk_cur;
      led          <= led_nxt;
    end
  end

endmodule

// File: tb/tb_mode_switch_controller.sv
// Scoreboarded bench: expected restart pulses are queued as selects are driven
// and popped by a monitor; gap length, latency and source muxing are checked inline.
module tb_mode_switch_controller;

  localparam int NM = 3;
  localparam int MW = 3;
  localparam int LW = 7;
  localparam int DB = 4;
  localparam int MU = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [MW-1:0]     mode_select = '0;
  logic [NM-1:0]     src_speaker = '0;
  logic [NM*LW-1:0]  src_led = '0;
  logic [MW-1:0]     current_mode;
  logic [NM-1:0]     mode_active;
  logic [NM-1:0]     mode_restart;
  logic              switching;
  logic              speaker;
  logic              loud;
  logic [LW-1:0]     led;

  int                n_chk = 0;
  int                n_fail = 0;
  logic [NM-1:0]     rq[$];
  logic [NM-1:0]     rq_exp;
  logic [NM-1:0]     p_spk;
  logic [NM*LW-1:0]  p_led;

  always #5 clk = ~clk;

  mode_switch_controller #(
    .NUM_MODES(NM), .MODE_W(MW), .LED_W(LW), .DEFAULT_MODE(0),
    .DEBOUNCE_CYCLES(DB), .MUTE_CYCLES(MU)
  ) dut (
    .clk(clk), .reset(reset), .mode_select(mode_select),
    .src_speaker(src_speaker), .src_led(src_led),
    .current_mode(current_mode), .mode_active(mode_active),
    .mode_restart(mode_restart), .switching(switching),
    .speaker(speaker), .loud(loud), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; remembers the sources the DUT sampled on this edge.
  task automatic step();
    p_spk = src_speaker;
    p_led = src_led;
    @(posedge clk);
    #1;
    src_speaker = NM'($urandom);
    src_led     = (NM*LW)'($urandom);
  endtask

  task automatic wait_mode(input int m, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (int'(current_mode) != m && k < 20);
  endtask

  // Counts cycles with the amplifier off from now; tracks switching and speaker.
  task automatic gap(output int n, output int sw, output bit quiet);
    n = 0; sw = 0; quiet = 1'b1;
    while (!loud && n < 40) begin
      if (speaker) quiet = 1'b0;
      if (switching) sw++;
      n++;
      step();
    end
  endtask

  task automatic follow(input string tag, input int m);
    chk({tag, "_loud"}, 32'(loud), 1);
    chk({tag, "_spk"}, 32'(speaker), 32'(p_spk[m]));
    chk({tag, "_led"}, 32'(led), 32'(p_led[m*LW +: LW]));
  endtask

  always @(negedge clk) begin
    if (reset && mode_restart != '0) begin
      if (rq.size() == 0) chk("unexp_restart", 32'(mode_restart), 0);
      else begin
        rq_exp = rq.pop_front();
        chk("restart", 32'(mode_restart), 32'(rq_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int  k, n, sw;
    bit  q, ok;

    repeat (3) step();
    chk("rst_mode", 32'(current_mode), 0);
    chk("rst_active", 32'(mode_active), 1);
    chk("rst_restart", 32'(mode_restart), 0);
    chk("rst_switching", 32'(switching), 0);
    chk("rst_speaker", 32'(speaker), 0);
    chk("rst_loud", 32'(loud), 0);
    chk("rst_led", 32'(led), 0);

    // power-up gap
    reset = 1'b1;
    gap(n, sw, q);
    chk("pwr_gap", 32'(n), MU);
    chk("pwr_quiet", 32'(q), 1);
    follow("pwr", 0);
    repeat (3) begin step(); follow("run0", 0); end

    // 0 -> 2
    rq.push_back(3'b100);
    mode_select = 3'd2;
    wait_mode(2, k);
    chk("acc_lat_2", 32'(k), DB + 1);
    chk("active_2", 32'(mode_active), 32'(3'b100));
    chk("led_new_2", 32'(led), 32'(p_led[14 +: LW]));
    gap(n, sw, q);
    chk("gap_2", 32'(n), MU);
    chk("sw_2", 32'(sw), MU);
    chk("quiet_2", 32'(q), 1);
    follow("act2", 2);

    // bounce 2 -> 1 for 3 cycles then back: no switch
    mode_select = 3'd1;
    repeat (3) step();
    mode_select = 3'd2;
    ok = 1'b1;
    repeat (12) begin
      step();
      if (switching || !loud || speaker !== p_spk[2] || current_mode != 3'd2) ok = 1'b0;
    end
    chk("bounce_steady", 32'(ok), 1);

    // to mode 1, then out-of-range select falls back to mode 0
    rq.push_back(3'b010);
    mode_select = 3'd1;
    wait_mode(1, k);
    chk("acc_lat_1", 32'(k), DB + 1);
    gap(n, sw, q);
    follow("act1", 1);
    rq.push_back(3'b001);
    mode_select = 3'd5;
    wait_mode(0, k);
    chk("acc_lat_oor", 32'(k), DB + 1);
    chk("active_oor", 32'(mode_active), 32'(3'b001));
    gap(n, sw, q);
    chk("gap_oor", 32'(n), MU);
    follow("act0", 0);

    // retarget: 0 -> 1 accepted, then 2 accepted while still muting
    rq.push_back(3'b010);
    mode_select = 3'd1;
    wait_mode(1, k);
    rq.push_back(3'b100);
    mode_select = 3'd2;
    wait_mode(2, k);
    chk("retgt_lat", 32'(k), DB + 1);
    chk("retgt_still_mute", 32'(switching), 1);
    gap(n, sw, q);
    chk("retgt_gap", 32'(n), MU);
    chk("retgt_quiet", 32'(q), 1);
    chk("retgt_mode", 32'(current_mode), 2);
    follow("act2b", 2);

    // reset mid-mute
    rq.push_back(3'b010);
    mode_select = 3'd1;
    wait_mode(1, k);
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_mode", 32'(current_mode), 0);
    chk("mid_rst_restart", 32'(mode_restart), 0);
    chk("mid_rst_switching", 32'(switching), 0);
    chk("mid_rst_speaker", 32'(speaker), 0);
    chk("mid_rst_loud", 32'(loud), 0);
    chk("mid_rst_led", 32'(led), 0);
    mode_select = 3'd0;
    repeat (2) step();
    reset = 1'b1;
    gap(n, sw, q);
    chk("rerst_gap", 32'(n), MU);
    chk("rerst_quiet", 32'(q), 1);
    follow("rerst", 0);
    repeat (2) step();
    chk("rq_drained", 32'(rq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
